// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: scans the four channels of a 4:1 MUX and assembles their samples into one word.
// Ports:
//   Clock_In     system clock, rising edge
//   Reset_n_In   asynchronous active-low reset
//   Start_In     scan request, accepted only in IDLE
//   Abort_In     synchronous abort of a running scan
//   Mux_Data_In  MUX output; sampled only while the MUX is enabled
//   Enable_Out   MUX enable
//   Select_Out   MUX channel select
//   Busy_Out     scan in progress
//   Done_Out     one-cycle pulse, Word_Out freshly valid
//   Word_Out     bit k = sample of channel k, held until the next completed scan
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       Clock_In,
  input  logic       Reset_n_In,
  input  logic       Start_In,
  input  logic       Abort_In,
  input  logic       Mux_Data_In,
  output logic       Enable_Out,
  output logic [1:0] Select_Out,
  output logic       Busy_Out,
  output logic       Done_Out,
  output logic [3:0] Word_Out
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] LP_CNT = 4'(SETTLE_CYCLES);
  // with no settle time every channel goes straight to its sample cycle
  localparam state_t LP_FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic [2:0] r_cap;
  logic [3:0] r_word;
  logic       r_active;
  logic       r_done;
  assign Enable_Out = r_active;
  assign Busy_Out   = r_active;
  assign Select_Out = r_sel;
  assign Done_Out   = r_done;
  assign Word_Out   = r_word;
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_cap    <= '0;
      r_word   <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (Start_In && !Abort_In) begin
          r_state  <= LP_FIRST;
          r_sel    <= '0;
          r_cnt    <= LP_CNT;
          r_active <= 1'b1;
        end
        SETTLE: if (Abort_In) begin
          r_state  <= IDLE;
          r_sel    <= '0;
          r_active <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= SAMPLE;
        end
        SAMPLE: if (Abort_In) begin
          r_state  <= IDLE;
          r_sel    <= '0;
          r_active <= 1'b0;
        end else if (r_sel != 2'd3) begin
          r_cap[r_sel] <= Mux_Data_In;
          r_sel        <= r_sel + 2'd1;
          r_cnt        <= LP_CNT;
          r_state      <= LP_FIRST;
        end else begin
          // last channel goes straight into the word, bypassing the capture register
          r_word   <= {Mux_Data_In, r_cap};
          r_sel    <= '0;
          r_active <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
